core_ctrl: RTL and testbench
============================

Name: core_ctrl

Overview:
- Instruction sequencer that sits directly upstream of the core and drives its 34-bit `inst` bus for one full convolution layer.
- Per kernel position kij, it runs these phases:
  - stream weight rows from activation/weight SRAM into L0;
  - load the weights into the PE array;
  - stream activations into L0 and execute;
  - drain the OFIFO into psum SRAM.
- After the last kij, it sweeps psum SRAM, feeding the SFP with the psum addresses each output pixel needs.

Parameters:
- ROW, 8, PE array rows (weight rows per kij)
- COL, 8, PE array columns
- KW, 3, kernel width; KIJ = KW*KW kernel positions
- IW, 6, input width; NIJ = IW*IW activation vectors
- OW, 4, output width (IW-KW+1); ONIJ = OW*OW outputs
- W_BASE, 11'd1024, xmem base address of the weights; kij block at W_BASE + kij*ROW
- LOAD_CYC, 16, cycles `inst[0]` is held during weight load (ROW+COL)

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low (port keeps the codebase name `reset`)
- start  in  1  one-cycle pulse; ignored unless in IDLE
- ofifo_valid  in  1  OFIFO has a full row available
- inst  out  34  core instruction bus, registered
- sfp_acc_clr  out  1  pulse coincident with the first `inst[33]` of each output pixel
- busy  out  1  high outside IDLE
- done  out  1  one-cycle pulse on the final ACC cycle

Behaviour:
- inst field map:
  - [33] sfp_i_valid
  - [32] psum CEN_n; [31] psum WEN_n; [30:20] psum A
  - [19] xmem CEN_n; [18] xmem WEN_n; [17:7] xmem A
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr
  - [1] execute; [0] load
- Reset (async, reset=0):
  - inst = 34'h1800C0000 (CEN_n/WEN_n high, all else 0);
  - sfp_acc_clr=0, busy=0, done=0;
  - state=IDLE; all counters 0.
- Reset mid-operation aborts immediately to these values. There is no partial-state retention.
- All outputs are registered. SRAM read latency is 1 cycle, so the `l0_wr` pulse for a read issued at cycle t is asserted at t+1.
- States: IDLE, W2L0, WLOAD, X2L0, EXEC, DRAIN, ACC, FIN.
  - IDLE -> W2L0 on start.
  - W2L0:
    - xmem read at A = W_BASE + kij*ROW + r, r = 0..ROW-1;
    - `l0_wr` follows one cycle later;
    - -> WLOAD after the last `l0_wr`.
  - WLOAD: `inst[0]`=1 and `l0_rd`=1 for LOAD_CYC cycles -> X2L0.
  - X2L0: xmem read at A = n, n = 0..NIJ-1; `l0_wr` delayed 1 cycle -> EXEC.
  - EXEC: `inst[1]`=1 and `l0_rd`=1 for NIJ cycles -> DRAIN.
  - DRAIN:
    - each cycle with ofifo_valid=1: `ofifo_rd`=1 and psum write (CEN_n=0, WEN_n=0) at A = kij*NIJ + m; m increments;
    - ofifo_valid=0 is a stall: no write, no increment, no timeout;
    - after m = NIJ-1: kij<KIJ-1 -> kij++, W2L0; else -> ACC.
  - ACC:
    - for o = 0..ONIJ-1, k = 0..KIJ-1, psum read at A = k*NIJ + (o/OW + k/KW)*IW + (o%OW + k%KW);
    - `inst[33]`=1 one cycle after each read;
    - sfp_acc_clr=1 with the `inst[33]` belonging to k=0;
    - -> FIN after the last read.
  - FIN: drives the final `inst[33]` and done=1 -> IDLE.
- Address arithmetic:
  - done on unsigned 11-bit addresses;
  - parameters must satisfy KIJ*NIJ ≤ 2048 and W_BASE + KIJ*ROW ≤ 2048;
  - no wrap is expected, and addresses truncate modulo 2048 if violated.
- start while busy is ignored; busy=1 from the cycle after start until the cycle after done.
- Fields not active in a state are driven to their idle values (CEN_n/WEN_n=1, others 0).

Decomposition:
- Shared package `core_pkg`:
  - inst bit-index localparams (INST_SFP_V=33 … INST_LOAD=0) and field ranges;
  - INST_IDLE = 34'h1800C0000;
  - state enum constants.
- One sub-module, `conv_addr_gen`: pipelined (o,k) counter plus the ACC address computation, with 1-cycle latency.

Test Plan:
- Reset:
  - assert reset=0 mid-EXEC -> next edge-free sample shows inst=34'h1800C0000, busy=0, done=0;
  - release and pulse start -> first xmem read A=1024.
- W2L0, kij=0, default params -> 8 reads A=1024..1031; `l0_wr` high exactly cycles t+1..t+8; then `inst[0]` high 16 cycles.
- DRAIN with ofifo_valid toggling 1,0,1,… -> 36 psum writes at A=kij*36+0..35, none on valid=0 cycles; kij=8 writes A=288..323.
- ACC, o=5, k=4 -> psum A = 4*36 + (1+1)*6 + (1+1) = 158; `inst[33]` next cycle; sfp_acc_clr only with k=0 (A=7).
- Full run, ofifo_valid tied 1 -> exactly 144 `inst[33]` pulses and 16 sfp_acc_clr pulses; done one cycle; start during busy has no effect.

Source files
------------

// File: rtl/core_pkg.sv
// Shared constants, inst field map and state encoding for the core instruction sequencer.
package core_pkg;

    // Layer geometry
    localparam int unsigned ROW      = 8;
    localparam int unsigned COL      = 8;
    localparam int unsigned KW       = 3;
    localparam int unsigned KIJ      = KW * KW;
    localparam int unsigned IW       = 6;
    localparam int unsigned NIJ      = IW * IW;
    localparam int unsigned OW       = IW - KW + 1;
    localparam int unsigned ONIJ     = OW * OW;
    localparam int unsigned LOAD_CYC = ROW + COL;

    // Datapath widths
    localparam int unsigned AW     = 11;
    localparam int unsigned INST_W = 34;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned KIJ_W  = 4;
    localparam int unsigned IDX_W  = 4;

    localparam logic [AW-1:0] W_BASE = 11'd1024;

    // inst bit positions
    localparam int unsigned INST_SFP_V    = 33;
    localparam int unsigned INST_P_CEN    = 32;
    localparam int unsigned INST_P_WEN    = 31;
    localparam int unsigned INST_P_A_HI   = 30;
    localparam int unsigned INST_P_A_LO   = 20;
    localparam int unsigned INST_X_CEN    = 19;
    localparam int unsigned INST_X_WEN    = 18;
    localparam int unsigned INST_X_A_HI   = 17;
    localparam int unsigned INST_X_A_LO   = 7;
    localparam int unsigned INST_OFIFO_RD = 6;
    localparam int unsigned INST_IFIFO_WR = 5;
    localparam int unsigned INST_IFIFO_RD = 4;
    localparam int unsigned INST_L0_RD    = 3;
    localparam int unsigned INST_L0_WR    = 2;
    localparam int unsigned INST_EXEC     = 1;
    localparam int unsigned INST_LOAD     = 0;

    // Both SRAMs deselected, every strobe low
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1800C0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        W2L0  = 3'd1,
        WLOAD = 3'd2,
        X2L0  = 3'd3,
        EXEC  = 3'd4,
        DRAIN = 3'd5,
        ACC   = 3'd6,
        FIN   = 3'd7
    } state_t;

endpackage

// File: rtl/core_ctrl_if.sv
// Sequencer <-> core/host bundle.
// master: the sequencer (drives inst, sfp_acc_clr, busy, done; takes start, ofifo_valid).
// slave : the host/core side.
interface core_ctrl_if
    import core_pkg::*;
;
    logic              start;
    logic              ofifo_valid;
    logic [INST_W-1:0] inst;
    logic              sfp_acc_clr;
    logic              busy;
    logic              done;

    modport master (
        input  start, ofifo_valid,
        output inst, sfp_acc_clr, busy, done
    );

    modport slave (
        output start, ofifo_valid,
        input  inst, sfp_acc_clr, busy, done
    );
endinterface

// File: rtl/conv_addr_gen.sv
// Psum read-address generator for the accumulation sweep.
// Walks (o,k) with k innermost and emits one registered address per cycle after i_start.
// Ports: clk, rst_n; i_start (arm, counters to 0); o_valid/o_addr/o_first (k==0)/o_last.
module conv_addr_gen
    import core_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    output logic          o_valid,
    output logic [AW-1:0] o_addr,
    output logic          o_first,
    output logic          o_last
);

    logic [IDX_W-1:0] r_ox;
    logic [IDX_W-1:0] r_oy;
    logic [IDX_W-1:0] r_kx;
    logic [IDX_W-1:0] r_ky;
    logic [IDX_W-1:0] r_k;
    logic             r_active;

    logic [AW-1:0] w_addr;
    logic          w_first;
    logic          w_last;

    // k*NIJ + (oy+ky)*IW + (ox+kx), with o = oy*OW+ox and k = ky*KW+kx
    assign w_addr  = AW'(r_k * NIJ) + AW'((r_oy + r_ky) * IW) + AW'(r_ox + r_kx);
    assign w_first = (r_kx == '0) && (r_ky == '0);
    assign w_last  = (r_kx == IDX_W'(KW - 1)) && (r_ky == IDX_W'(KW - 1)) &&
                     (r_ox == IDX_W'(OW - 1)) && (r_oy == IDX_W'(OW - 1));

    // Counter walk plus one-cycle output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ox     <= '0;
            r_oy     <= '0;
            r_kx     <= '0;
            r_ky     <= '0;
            r_k      <= '0;
            r_active <= 1'b0;
            o_valid  <= 1'b0;
            o_addr   <= '0;
            o_first  <= 1'b0;
            o_last   <= 1'b0;
        end else begin
            o_valid <= 1'b0;
            if (i_start) begin
                r_ox     <= '0;
                r_oy     <= '0;
                r_kx     <= '0;
                r_ky     <= '0;
                r_k      <= '0;
                r_active <= 1'b1;
            end else if (r_active) begin
                o_valid <= 1'b1;
                o_addr  <= w_addr;
                o_first <= w_first;
                o_last  <= w_last;
                if (w_last) begin
                    r_active <= 1'b0;
                end
                // All counters wrap to zero on the last step
                if (r_kx != IDX_W'(KW - 1)) begin
                    r_kx <= r_kx + 1'b1;
                    r_k  <= r_k + 1'b1;
                end else begin
                    r_kx <= '0;
                    if (r_ky != IDX_W'(KW - 1)) begin
                        r_ky <= r_ky + 1'b1;
                        r_k  <= r_k + 1'b1;
                    end else begin
                        r_ky <= '0;
                        r_k  <= '0;
                        if (r_ox != IDX_W'(OW - 1)) begin
                            r_ox <= r_ox + 1'b1;
                        end else begin
                            r_ox <= '0;
                            r_oy <= (r_oy == IDX_W'(OW - 1)) ? '0 : r_oy + 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/core_ctrl.sv
// Convolution-layer instruction sequencer driving the core's 34-bit inst bus.
// Ports: clk; reset (async, active-low); bus (core_ctrl_if.master):
//   start, ofifo_valid in; inst, sfp_acc_clr, busy, done out (all registered).
module core_ctrl
    import core_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    core_ctrl_if.master        bus
);

    state_t            r_state;
    logic [KIJ_W-1:0]  r_kij;
    logic [CNT_W-1:0]  r_cnt;
    logic [INST_W-1:0] r_inst;
    logic              r_sfp_pend;
    logic              r_clr_pend;
    logic              r_clr;
    logic              r_busy;
    logic              r_done;

    logic [INST_W-1:0] w_inst_nxt;
    logic              w_gen_start;
    logic              w_gen_valid;
    logic [AW-1:0]     w_gen_addr;
    logic              w_gen_first;
    logic              w_gen_last;

    assign bus.inst        = r_inst;
    assign bus.sfp_acc_clr = r_clr;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;

    // Arm the sweep on the final psum write of the last kernel position
    assign w_gen_start = (r_state == DRAIN) && bus.ofifo_valid &&
                         (r_cnt == CNT_W'(NIJ - 1)) && (r_kij == KIJ_W'(KIJ - 1));

    conv_addr_gen u_addr_gen (
        .clk     (clk),
        .rst_n   (reset),
        .i_start (w_gen_start),
        .o_valid (w_gen_valid),
        .o_addr  (w_gen_addr),
        .o_first (w_gen_first),
        .o_last  (w_gen_last)
    );

    // Next inst word; the SRAM read in cycle t is paired with l0_wr in cycle t+1
    always_comb begin
        w_inst_nxt             = INST_IDLE;
        w_inst_nxt[INST_SFP_V] = r_sfp_pend;
        case (r_state)
            W2L0: begin
                if (r_cnt < CNT_W'(ROW)) begin
                    w_inst_nxt[INST_X_CEN] = 1'b0;
                    w_inst_nxt[INST_X_A_HI:INST_X_A_LO] =
                        W_BASE + AW'(r_kij * ROW) + AW'(r_cnt);
                end
                if (r_cnt != '0) w_inst_nxt[INST_L0_WR] = 1'b1;
            end
            WLOAD: begin
                w_inst_nxt[INST_LOAD]  = 1'b1;
                w_inst_nxt[INST_L0_RD] = 1'b1;
            end
            X2L0: begin
                if (r_cnt < CNT_W'(NIJ)) begin
                    w_inst_nxt[INST_X_CEN] = 1'b0;
                    w_inst_nxt[INST_X_A_HI:INST_X_A_LO] = AW'(r_cnt);
                end
                if (r_cnt != '0) w_inst_nxt[INST_L0_WR] = 1'b1;
            end
            EXEC: begin
                w_inst_nxt[INST_EXEC]  = 1'b1;
                w_inst_nxt[INST_L0_RD] = 1'b1;
            end
            DRAIN: begin
                if (bus.ofifo_valid) begin
                    w_inst_nxt[INST_OFIFO_RD] = 1'b1;
                    w_inst_nxt[INST_P_CEN]    = 1'b0;
                    w_inst_nxt[INST_P_WEN]    = 1'b0;
                    w_inst_nxt[INST_P_A_HI:INST_P_A_LO] =
                        AW'(r_kij * NIJ) + AW'(r_cnt);
                end
            end
            ACC: begin
                if (w_gen_valid) begin
                    w_inst_nxt[INST_P_CEN] = 1'b0;
                    w_inst_nxt[INST_P_A_HI:INST_P_A_LO] = w_gen_addr;
                end
            end
            default: ;
        endcase
    end

    // Phase sequencing and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_kij      <= '0;
            r_cnt      <= '0;
            r_inst     <= INST_IDLE;
            r_sfp_pend <= 1'b0;
            r_clr_pend <= 1'b0;
            r_clr      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_inst     <= w_inst_nxt;
            r_sfp_pend <= (r_state == ACC) && w_gen_valid;
            r_clr_pend <= (r_state == ACC) && w_gen_valid && w_gen_first;
            r_clr      <= r_clr_pend;
            r_done     <= 1'b0;
            case (r_state)
                IDLE: begin
                    // busy is still high in the done cycle, so a start there is dropped
                    r_busy <= bus.start && !r_busy;
                    if (bus.start && !r_busy) begin
                        r_state <= W2L0;
                        r_kij   <= '0;
                        r_cnt   <= '0;
                    end
                end
                W2L0: begin
                    if (r_cnt == CNT_W'(ROW)) begin
                        r_cnt   <= '0;
                        r_state <= WLOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WLOAD: begin
                    if (r_cnt == CNT_W'(LOAD_CYC - 1)) begin
                        r_cnt   <= '0;
                        r_state <= X2L0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                X2L0: begin
                    if (r_cnt == CNT_W'(NIJ)) begin
                        r_cnt   <= '0;
                        r_state <= EXEC;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                EXEC: begin
                    if (r_cnt == CNT_W'(NIJ - 1)) begin
                        r_cnt   <= '0;
                        r_state <= DRAIN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    // ofifo_valid low is a stall with no timeout
                    if (bus.ofifo_valid) begin
                        if (r_cnt == CNT_W'(NIJ - 1)) begin
                            r_cnt <= '0;
                            if (r_kij == KIJ_W'(KIJ - 1)) begin
                                r_state <= ACC;
                            end else begin
                                r_kij   <= r_kij + 1'b1;
                                r_state <= W2L0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ACC: begin
                    if (w_gen_valid && w_gen_last) r_state <= FIN;
                end
                FIN: begin
                    r_done  <= 1'b1;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed bench for core_ctrl: a negedge monitor logs inst-bus events, then
// table vectors and hand-written sequences compare them with hand-computed values.
module tb_core_ctrl;
    import core_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    core_ctrl_if dif ();

    core_ctrl u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // ---------------- monitor ----------------
    logic          mon_clr = 1'b0;
    bit            v_mode  = 1'b1;   // 1: ofifo_valid toggles, 0: tied high
    int            cyc = 0;
    logic [10:0]   xrd_q[$];
    logic [10:0]   pwr_q[$];
    logic [10:0]   prd_q[$];
    bit            clr_q[$];
    int            l0wr_q[$];
    int            load_q[$];
    int            x0_cyc, n_sfp, n_clr, n_done, bad, done_cyc, last_sfp_cyc;
    int            busy_at_done, busy_after;
    logic          cur_v = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (mon_clr) begin
                xrd_q.delete(); pwr_q.delete(); prd_q.delete(); clr_q.delete();
                l0wr_q.delete(); load_q.delete();
                x0_cyc = -1; n_sfp = 0; n_clr = 0; n_done = 0; bad = 0;
                done_cyc = -10; last_sfp_cyc = -1; busy_at_done = -1; busy_after = -1;
            end else if (reset) begin
                if (!dif.inst[INST_X_CEN]) begin
                    xrd_q.push_back(dif.inst[INST_X_A_HI:INST_X_A_LO]);
                    if (xrd_q.size() == 1) x0_cyc = cyc;
                end
                if (dif.inst[INST_L0_WR]) l0wr_q.push_back(cyc);
                if (dif.inst[INST_LOAD])  load_q.push_back(cyc);
                if (!dif.inst[INST_P_CEN] && !dif.inst[INST_P_WEN]) begin
                    pwr_q.push_back(dif.inst[INST_P_A_HI:INST_P_A_LO]);
                    if (!dif.inst[INST_OFIFO_RD] || !cur_v) bad++;
                end
                if (!dif.inst[INST_P_CEN] && dif.inst[INST_P_WEN])
                    prd_q.push_back(dif.inst[INST_P_A_HI:INST_P_A_LO]);
                if (dif.inst[INST_SFP_V]) begin
                    n_sfp++;
                    clr_q.push_back(dif.sfp_acc_clr);
                    last_sfp_cyc = cyc;
                end
                if (dif.sfp_acc_clr) begin
                    n_clr++;
                    if (!dif.inst[INST_SFP_V]) bad++;
                end
                if (dif.done) begin
                    n_done++;
                    done_cyc = cyc;
                    busy_at_done = int'(dif.busy);
                end
                if (cyc == done_cyc + 1) busy_after = int'(dif.busy);
            end
            cur_v = dif.ofifo_valid;
        end
    end

    // ofifo_valid driver
    initial begin
        dif.ofifo_valid = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (v_mode) dif.ofifo_valid = ~dif.ofifo_valid;
            else        dif.ofifo_valid = 1'b1;
        end
    end

    task automatic mon_clear();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        #1 dif.start = 1'b1;
        @(negedge clk);
        #1 dif.start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (n_done == 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("done_seen", 64'(n_done != 0), 64'd1);
        repeat (3) @(negedge clk);
        #1;
    endtask

    // ---------------- vector table ----------------
    // kind 0: xmem read  [a=kij, b=slot within kij (0..7 weights, 8.. acts)]
    // kind 1: psum write [a=kij, b=m]
    // kind 2: psum read  [a=o, b=k]
    // kind 3: sfp_acc_clr with inst[33] [a=o, b=k]
    typedef struct {
        int          kind;
        int          a;
        int          b;
        logic [63:0] exp;
    } vec_t;
    vec_t vecs[$];

    task automatic run_vectors();
        foreach (vecs[i]) begin
            int          idx;
            logic [63:0] act;
            act = '1;
            case (vecs[i].kind)
                0: begin idx = vecs[i].a * 44 + vecs[i].b;
                         if (idx < xrd_q.size()) act = 64'(xrd_q[idx]); end
                1: begin idx = vecs[i].a * 36 + vecs[i].b;
                         if (idx < pwr_q.size()) act = 64'(pwr_q[idx]); end
                2: begin idx = vecs[i].a * 9 + vecs[i].b;
                         if (idx < prd_q.size()) act = 64'(prd_q[idx]); end
                default: begin idx = vecs[i].a * 9 + vecs[i].b;
                         if (idx < clr_q.size()) act = 64'(clr_q[idx]); end
            endcase
            chk($sformatf("vec%0d_kind%0d_a%0d_b%0d", i, vecs[i].kind, vecs[i].a, vecs[i].b),
                act, vecs[i].exp);
        end
    endtask

    initial begin
        int seq_ok;
        int n;

        vecs.push_back('{0, 0, 0, 64'd1024});
        vecs.push_back('{0, 0, 7, 64'd1031});
        vecs.push_back('{0, 1, 0, 64'd1032});
        vecs.push_back('{0, 8, 0, 64'd1088});
        vecs.push_back('{0, 8, 7, 64'd1095});
        vecs.push_back('{0, 0, 8, 64'd0});
        vecs.push_back('{0, 2, 43, 64'd35});
        vecs.push_back('{1, 0, 0, 64'd0});
        vecs.push_back('{1, 0, 35, 64'd35});
        vecs.push_back('{1, 4, 17, 64'd161});
        vecs.push_back('{1, 8, 0, 64'd288});
        vecs.push_back('{1, 8, 35, 64'd323});
        vecs.push_back('{2, 0, 0, 64'd0});
        vecs.push_back('{2, 5, 4, 64'd158});
        vecs.push_back('{2, 5, 0, 64'd7});
        vecs.push_back('{2, 0, 8, 64'd302});
        vecs.push_back('{2, 15, 8, 64'd323});
        vecs.push_back('{2, 3, 1, 64'd40});
        vecs.push_back('{2, 12, 3, 64'd132});
        vecs.push_back('{3, 0, 0, 64'd1});
        vecs.push_back('{3, 5, 0, 64'd1});
        vecs.push_back('{3, 7, 0, 64'd1});
        vecs.push_back('{3, 5, 4, 64'd0});
        vecs.push_back('{3, 15, 8, 64'd0});

        // Reset state
        reset     = 1'b0;
        dif.start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_inst", 64'(dif.inst), 64'(INST_IDLE));
        chk("rst_busy", 64'(dif.busy), 64'd0);
        chk("rst_done", 64'(dif.done), 64'd0);
        chk("rst_clr",  64'(dif.sfp_acc_clr), 64'd0);
        reset = 1'b1;

        // Run 1: ofifo_valid toggling, start re-pulsed while busy
        v_mode = 1'b1;
        mon_clear();
        pulse_start();
        chk("busy_after_start", 64'(dif.busy), 64'd1);
        repeat (300) @(negedge clk);
        pulse_start();
        wait_done(6000);

        chk("x_reads_total", 64'(xrd_q.size()), 64'd396);
        chk("l0wr_first",  64'(l0wr_q[0] - x0_cyc), 64'd1);
        chk("l0wr_eighth", 64'(l0wr_q[7] - x0_cyc), 64'd8);
        chk("l0wr_ninth",  64'(l0wr_q[8] - x0_cyc), 64'd26);
        chk("load_first",  64'(load_q[0] - x0_cyc), 64'd9);
        chk("load_16th",   64'(load_q[15] - x0_cyc), 64'd24);
        chk("load_total",  64'(load_q.size()), 64'd144);
        run_vectors();

        chk("psum_wr_total", 64'(pwr_q.size()), 64'd324);
        seq_ok = 1;
        foreach (pwr_q[i]) if (int'(pwr_q[i]) != i) seq_ok = 0;
        chk("psum_wr_sequential", 64'(seq_ok), 64'd1);
        chk("wr_strobe_violations", 64'(bad), 64'd0);
        chk("psum_rd_total", 64'(prd_q.size()), 64'd144);
        chk("sfp_pulses", 64'(n_sfp), 64'd144);
        chk("clr_pulses", 64'(n_clr), 64'd16);
        chk("done_cycles", 64'(n_done), 64'd1);
        chk("last_sfp_with_done", 64'(last_sfp_cyc == done_cyc), 64'd1);
        chk("busy_in_done_cycle", 64'(busy_at_done), 64'd1);
        chk("busy_after_done", 64'(busy_after), 64'd0);

        // Run 2: ofifo_valid tied high
        v_mode = 1'b0;
        mon_clear();
        pulse_start();
        wait_done(4000);
        chk("r2_sfp_pulses", 64'(n_sfp), 64'd144);
        chk("r2_clr_pulses", 64'(n_clr), 64'd16);
        chk("r2_done_cycles", 64'(n_done), 64'd1);
        chk("r2_psum_wr_total", 64'(pwr_q.size()), 64'd324);
        chk("r2_violations", 64'(bad), 64'd0);

        // Run 3: reset mid-EXEC, then restart
        mon_clear();
        pulse_start();
        n = 0;
        while (!dif.inst[INST_EXEC] && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("exec_seen", 64'(dif.inst[INST_EXEC]), 64'd1);
        #1 reset = 1'b0;
        #1;
        chk("abort_inst", 64'(dif.inst), 64'(INST_IDLE));
        chk("abort_busy", 64'(dif.busy), 64'd0);
        chk("abort_done", 64'(dif.done), 64'd0);
        @(negedge clk);
        #1 reset = 1'b1;
        mon_clear();
        pulse_start();
        n = 0;
        while (xrd_q.size() == 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("restart_first_xrd", (xrd_q.size() != 0) ? 64'(xrd_q[0]) : '1, 64'd1024);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
